// File: rtl/anc_ctrl.sv
// ANC LMS sequencer: buffers (x,d) sample pairs, launches the external FIR once per pair and turns the
// returned error into a saturated LMS weight step. Define ANC_CTRL_TIMEOUT_EN to add the WAIT watchdog.
module anc_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int MU_SHIFT    = 12,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x_sample,
  input  logic [15:0] d_sample,
  input  logic [15:0] mu,
  output logic        fir_go,
  output logic [15:0] x_in,
  output logic [15:0] a_in,
  output logic [15:0] weight_adjust,
  input  logic        fir_done,
  input  logic [15:0] fir_sample,
  input  logic        fir_act,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] err_out,
  output logic        busy,
  output logic        timeout_err
);

  localparam int DATA_W = 16;
  localparam int PROD_W = 2 * DATA_W;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic signed [PROD_W-1:0] SAT_MAX = 32767;
  localparam logic signed [PROD_W-1:0] SAT_MIN = -32768;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_EMIT   = 3'd4
  } state_t;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [PROD_W-1:0] v);
    if (v > SAT_MAX) begin
      return 16'sh7FFF;
    end else if (v < SAT_MIN) begin
      return 16'sh8000;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  // Negated, scaled e*mu; the negation cannot overflow because the shifted product is at most 2^30.
  function automatic logic signed [DATA_W-1:0] lms_term(input logic signed [DATA_W-1:0] e,
                                                        input logic signed [DATA_W-1:0] m);
    logic signed [PROD_W-1:0] p;
    logic signed [PROD_W-1:0] q;
    p = $signed({{DATA_W{e[DATA_W-1]}}, e}) * $signed({{DATA_W{m[DATA_W-1]}}, m});
    q = p >>> MU_SHIFT;
    return sat16(-q);
  endfunction

  state_t state_q, state_d;

  logic [PROD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PROD_W-1:0] head;
  logic              push, pop;

  logic signed [DATA_W-1:0] e_q, e_d;
  logic [DATA_W-1:0]        x_q, x_d;
  logic [DATA_W-1:0]        a_q, a_d;
  logic signed [DATA_W-1:0] wa_q, wa_d;

`ifdef ANC_CTRL_TIMEOUT_EN
  localparam int WC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT_CYC - 1);
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic            tmo_q, tmo_d;
`endif

  // Sample-pair FIFO; in_ready looks only at the registered count, never at this cycle's pop.
  assign in_ready = (count_q != CNT_FULL);
  assign push     = in_valid && in_ready;
  assign head     = fifo_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {x_sample, d_sample};
    end
  end

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    x_d     = x_q;
    a_d     = a_q;
    wa_d    = wa_q;
    pop     = 1'b0;
`ifdef ANC_CTRL_TIMEOUT_EN
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !fir_act) begin
          pop     = 1'b1;
          x_d     = head[PROD_W-1:DATA_W];
          a_d     = head[DATA_W-1:0];
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef ANC_CTRL_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      S_WAIT: begin
        if (fir_done) begin
          e_d     = fir_sample;
          state_d = S_UPDATE;
        end
`ifdef ANC_CTRL_TIMEOUT_EN
        else if (wcnt_q == WC_LAST) begin
          e_d     = '0;
          tmo_d   = 1'b1;
          state_d = S_UPDATE;
        end else begin
          wcnt_d  = wcnt_q + WC_W'(1);
        end
`endif
      end
      S_UPDATE: begin
        wa_d    = lms_term(e_q, mu);
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      e_q      <= '0;
      x_q      <= '0;
      a_q      <= '0;
      wa_q     <= '0;
`ifdef ANC_CTRL_TIMEOUT_EN
      wcnt_q   <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      e_q      <= e_d;
      x_q      <= x_d;
      a_q      <= a_d;
      wa_q     <= wa_d;
`ifdef ANC_CTRL_TIMEOUT_EN
      wcnt_q   <= wcnt_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign fir_go        = (state_q == S_LAUNCH);
  assign out_valid     = (state_q == S_EMIT);
  assign busy          = (state_q != S_IDLE);
  assign x_in          = x_q;
  assign a_in          = a_q;
  assign weight_adjust = wa_q;
  assign err_out       = e_q;

`ifdef ANC_CTRL_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/anc_ctrl.md
ANC_CTRL -- requirements
Module: anc_ctrl

Interface
REQ-001: Parameter FIFO_DEPTH, default 4, is the input sample-pair FIFO depth (power of two, >=2).
REQ-002: Parameter MU_SHIFT, default 12, is the right-shift applied to the error*mu product.
REQ-003: Parameter TIMEOUT_CYC, default 1023, is the WAIT-state watchdog limit; it is used only with ANC_CTRL_TIMEOUT_EN.
REQ-004: clk  in  1  sole clock; all logic is on the rising edge.
REQ-005: rst_n  in  1  reset, synchronous, active-low.
REQ-006: in_valid  in  1  upstream sample pair valid.
REQ-007: in_ready  out  1  FIFO not full.
REQ-008: x_sample  in  16  signed Q1.15 reference-noise sample.
REQ-009: d_sample  in  16  signed Q1.15 primary-mic sample.
REQ-010: mu  in  16  signed step size, sampled in the UPDATE state.
REQ-011: fir_go  out  1  one-cycle FIR start pulse.
REQ-012: x_in  out  16  reference sample to the FIR.
REQ-013: a_in  out  16  primary sample to the FIR (accumulator seed).
REQ-014: weight_adjust  out  16  signed LMS update term to the FIR.
REQ-015: fir_done  in  1  FIR completion pulse.
REQ-016: fir_sample  in  16  FIR result, treated as error e.
REQ-017: fir_act  in  1  FIR busy.
REQ-018: out_valid  out  1  error sample valid.
REQ-019: out_ready  in  1  downstream accept.
REQ-020: err_out  out  16  error sample.
REQ-021: busy  out  1  high whenever the FSM is not in IDLE.
REQ-022: timeout_err  out  1  sticky watchdog flag.

Function
REQ-023: FIFO push SHALL occur on in_valid && in_ready; pointers wrap modulo FIFO_DEPTH; in_ready = (count != FIFO_DEPTH) and SHALL NOT depend combinationally on a same-cycle pop.
REQ-024: Simultaneous push and pop SHALL leave count unchanged and lose no data; a push while full SHALL be ignored.
REQ-025: The FSM states are IDLE, LAUNCH, WAIT, UPDATE, EMIT.
REQ-026: IDLE -> LAUNCH occurs when count != 0 && !fir_act.
- The FIFO head is popped.
- x_in and a_in are registered from it.
- Otherwise the FSM stays in IDLE (a high fir_act stalls the launch).
REQ-027: LAUNCH SHALL drive fir_go=1 for exactly one cycle, with x_in, a_in and weight_adjust stable, then go to WAIT.
REQ-028: In WAIT, fir_done SHALL capture e <= fir_sample and move the FSM to UPDATE; fir_done in any other state SHALL be ignored.
REQ-029: UPDATE SHALL compute and register weight_adjust in one cycle, then go to EMIT.
- p = e*mu as 32-bit signed.
- q = p >>> MU_SHIFT (arithmetic).
- weight_adjust = sat16(-q), clamped to [-32768, 32767].
REQ-030: The weight_adjust computed from sample n SHALL be the value presented with the fir_go of sample n+1, and SHALL hold until the next UPDATE.
REQ-031: EMIT SHALL assert out_valid with err_out = e, holding both stable until out_ready; on out_valid && out_ready it SHALL go to IDLE.
REQ-032: Minimum per-sample latency from pop to out_valid is LAUNCH(1) + FIR time + UPDATE(1) cycles; FIFO pushes continue during all states.

Reset
REQ-033: While rst_n=0 at a clk edge, all state SHALL clear.
- FSM goes to IDLE.
- FIFO count, read pointer and write pointer go to 0.
- e = 0.
- fir_go, x_in, a_in, weight_adjust, out_valid, err_out, busy and timeout_err go to 0.
- in_ready is 1 after reset.
REQ-034: Reset asserted mid-operation SHALL discard any in-flight sample and the FIFO contents; a later fir_done SHALL be ignored because the FSM is in IDLE.

Configuration
REQ-035: Macro ANC_CTRL_TIMEOUT_EN defined:
- A WAIT-cycle counter starts at 0 on WAIT entry.
- If it reaches TIMEOUT_CYC without fir_done, the block sets e=0 and timeout_err=1 (sticky until reset) and goes to UPDATE.
- That UPDATE yields weight_adjust=0, and the block then emits err_out=0.
REQ-036: Macro ANC_CTRL_TIMEOUT_EN undefined: there is no counter, WAIT waits indefinitely, and timeout_err is constant 0.

Verification
REQ-037: After reset, push x=0x0800, d=0x1000 -> one fir_go pulse with x_in=0x0800, a_in=0x1000, weight_adjust=0x0000.
REQ-038: Return fir_sample=0x0400 with mu=0x4000 -> weight_adjust=0xF000, out_valid with err_out=0x0400; the next fir_go carries 0xF000.
REQ-039: e=0x7FFF, mu=0x7FFF -> weight_adjust saturates to 0x8000.
REQ-040: Push 5 pairs with fir_act=1 held -> 4 accepted and in_ready=0; release fir_act -> the 4 pairs are processed in order.
REQ-041: Hold out_ready=0 in EMIT for 10 cycles -> err_out stays stable and no new fir_go is issued; assert rst_n=0 in WAIT -> all outputs 0 on the next cycle.
REQ-042: With ANC_CTRL_TIMEOUT_EN and no fir_done -> after 1023 WAIT cycles, timeout_err=1 and err_out=0 is emitted.
